// File: rtl/contador_ctrl.sv
// -----------------------------------------------------------------------------
// contador_ctrl
//
// Run controller for a W-bit up-counter (counter pins CLK/CLR/C, output Q).
// It sequences a run as IDLE -> CLEAR -> RUN (-> PAUSE -> RUN) -> DONE. It
// drives the counter's count enable and a registered clear request. It also
// watches the counter's Q so that the run stops, or reloads, at a limit that is
// captured when the run starts.
//
// Parameters
//   W      counter width; must equal the counter's Q width
//   PRESC  prescaler; one count tick every PRESC+1 clk cycles while in RUN
//          (0..255)
//
// Ports
//   clk_i      in   1  single clock, also clocks the counter
//   clr_i      in   1  asynchronous active-high reset
//   start_i    in   1  level: start (IDLE/DONE) or resume (PAUSE)
//   stop_i     in   1  level: pause a run (wins over start and terminal)
//   mode_i     in   1  0 = one-shot, 1 = auto-reload; captured on start
//   lim_i      in   W  terminal count; captured on start
//   qin_i      in   W  counter Q, fed back
//   ce_o       out  1  count enable to the counter's C input (combinational)
//   cclr_o     out  1  registered clear request, ORed with clr_i at the counter
//   busy_o     out  1  high in CLEAR, RUN and PAUSE
//   done_o     out  1  one-cycle registered pulse when the limit is reached
//   irq_o      out  1  sticky completion flag     (CTRL_STICKY_IRQ_EN only)
//   irq_ack_i  in   1  clears irq_o               (CTRL_STICKY_IRQ_EN only)
//
// Build option
//   CTRL_STICKY_IRQ_EN  adds irq_o/irq_ack_i. irq_o sets on every done pulse
//                       and clears on irq_ack_i. If both happen in the same
//                       cycle, the set wins. Without the macro, done_o is the
//                       only completion indicator.
// -----------------------------------------------------------------------------
module contador_ctrl #(
    parameter int W     = 10,
    parameter int PRESC = 0
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         mode_i,
    input  logic [W-1:0] lim_i,
    input  logic [W-1:0] qin_i,
    output logic         ce_o,
    output logic         cclr_o,
    output logic         busy_o,
    output logic         done_o
`ifdef CTRL_STICKY_IRQ_EN
    ,
    output logic         irq_o,
    input  logic         irq_ack_i
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The prescaler is fixed at 8 bits, which covers the full 0..255 range.
    localparam logic [7:0] PRESC_L = 8'(PRESC);

    state_t       state_q, state_d;
    logic [W-1:0] lim_q,   lim_d;
    logic         mode_q,  mode_d;
    logic [7:0]   presc_q, presc_d;
    logic         cclr_q,  cclr_d;
    logic         done_q,  done_d;

    logic tick;
    logic at_lim;

    assign tick   = (presc_q == PRESC_L);
    assign at_lim = (qin_i == lim_q);

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            presc_q <= '0;
            cclr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            cclr_q  <= cclr_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Level-sensitive: a START held high in DONE restarts at once.
                if (start_i) begin
                    state_d = S_CLEAR;
                    lim_d   = lim_i;
                    mode_d  = mode_i;
                end
            end

            S_CLEAR: begin
                state_d = S_RUN;
                presc_d = '0;
            end

            S_RUN: begin
                if (stop_i) begin
                    // STOP wins over the terminal count. The prescaler keeps
                    // its phase, so a resumed run ticks where it left off.
                    state_d = S_PAUSE;
                end else if (at_lim) begin
                    done_d  = 1'b1;
                    state_d = mode_q ? S_CLEAR : S_DONE;
                end else if (tick) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end

            S_PAUSE: begin
                if (start_i && !stop_i) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The clear request is registered from the next state. That way it is a
    // clean flop output that is high for exactly the one CLEAR cycle.
    assign cclr_d = (state_d == S_CLEAR);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // CE is gated by the limit compare, so the counter stops on the limit
    // value and never relies on its own wrap.
    assign ce_o   = (state_q == S_RUN) && tick && !at_lim && !stop_i;
    assign cclr_o = cclr_q;
    assign done_o = done_q;
    assign busy_o = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                    (state_q == S_PAUSE);

`ifdef CTRL_STICKY_IRQ_EN
    logic irq_q, irq_d;

    // Set from the registered done pulse. A done in the same cycle as an
    // acknowledge therefore still leaves the flag set.
    assign irq_d = done_q | (irq_q & ~irq_ack_i);

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_contador_ctrl.sv
module tb_contador_ctrl;

    logic       clk;
    logic       clr, start, stop, mode, ack;
    logic [9:0] lim, qin_tab;
    logic       use_cnt;
    logic [9:0] cnt0, cnt3, qin0, qin3;
    logic       ce0, cclr0, busy0, done0, irq0;
    logic       ce3, cclr3, busy3, done3, irq3;

    int n_cmp  = 0;
    int n_fail = 0;

    // statistics gathered by cyc()
    int cyc_no, n_ce0, n_cclr0, n_done0, n_ce3;
    int first_ce3, last_ce3, gap_err3, done3_cyc, q0_max;
    logic last_done0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign qin0 = use_cnt ? cnt0 : qin_tab;
    assign qin3 = use_cnt ? cnt3 : qin_tab;

    // Behavioural stand-ins for the two 10-bit counters
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt0 <= '0;
            cnt3 <= '0;
        end else begin
            if (cclr0)    cnt0 <= '0;
            else if (ce0) cnt0 <= cnt0 + 10'd1;
            if (cclr3)    cnt3 <= '0;
            else if (ce3) cnt3 <= cnt3 + 10'd1;
        end
    end

    contador_ctrl #(.W(10), .PRESC(0)) u_dut0 (
        .clk_i(clk), .clr_i(clr), .start_i(start), .stop_i(stop),
        .mode_i(mode), .lim_i(lim), .qin_i(qin0),
        .ce_o(ce0), .cclr_o(cclr0), .busy_o(busy0), .done_o(done0)
`ifdef CTRL_STICKY_IRQ_EN
        , .irq_o(irq0), .irq_ack_i(ack)
`endif
    );

    contador_ctrl #(.W(10), .PRESC(3)) u_dut3 (
        .clk_i(clk), .clr_i(clr), .start_i(start), .stop_i(stop),
        .mode_i(mode), .lim_i(lim), .qin_i(qin3),
        .ce_o(ce3), .cclr_o(cclr3), .busy_o(busy3), .done_o(done3)
`ifdef CTRL_STICKY_IRQ_EN
        , .irq_o(irq3), .irq_ack_i(ack)
`endif
    );

`ifndef CTRL_STICKY_IRQ_EN
    assign irq0 = 1'b0;
    assign irq3 = 1'b0;
`endif

    typedef struct {
        logic       clr, start, stop, mode;
        logic [9:0] lim, qin;
        logic       ce, cclr, busy, done;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(input logic c, s, p, m, input int l, q,
                                input logic e_ce, e_cclr, e_busy, e_done);
        vec_t v;
        v.clr = c; v.start = s; v.stop = p; v.mode = m;
        v.lim = 10'(l); v.qin = 10'(q);
        v.ce = e_ce; v.cclr = e_cclr; v.busy = e_busy; v.done = e_done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc_no = 0; n_ce0 = 0; n_cclr0 = 0; n_done0 = 0; n_ce3 = 0;
        first_ce3 = -1; last_ce3 = -1; gap_err3 = 0; done3_cyc = -1;
        q0_max = 0; last_done0 = 1'b0;
    endtask

    // One clock cycle: sample on the falling edge, return 1 time unit after
    // the next rising edge so that the caller can change inputs.
    task automatic cyc();
        @(negedge clk);
        cyc_no++;
        if (ce0)   n_ce0++;
        if (cclr0) n_cclr0++;
        if (done0) n_done0++;
        if (ce3) begin
            if (first_ce3 < 0) first_ce3 = cyc_no;
            else if (cyc_no - last_ce3 != 4) gap_err3++;
            last_ce3 = cyc_no;
            n_ce3++;
        end
        if (done3 && done3_cyc < 0) done3_cyc = cyc_no;
        if (int'(qin0) > q0_max) q0_max = int'(qin0);
        last_done0 = done0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;
        cyc();
        clr = 1'b0;
        clear_stats();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; ack = 1'b0;
        lim = '0; qin_tab = '0; use_cnt = 1'b0;
        clear_stats();

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst.ce",   ce0,   1'b0);
        chk("rst.cclr", cclr0, 1'b0);
        chk("rst.busy", busy0, 1'b0);
        chk("rst.done", done0, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;

        // ---------------- directed table (PRESC=0, QIN driven directly) ----
        //            clr st sp md lim qin   ce cclr busy done
        vt[0]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // idle
        vt[1]  = mk(0, 1, 0, 0, 3, 0,   0, 0, 0, 0); // start, lim=3
        vt[2]  = mk(0, 0, 0, 0, 7, 9,   0, 1, 1, 0); // CLEAR, LIM change ignored
        vt[3]  = mk(0, 0, 0, 0, 7, 0,   1, 0, 1, 0); // RUN counting
        vt[4]  = mk(0, 0, 1, 0, 7, 1,   0, 0, 1, 0); // STOP kills CE
        vt[5]  = mk(0, 0, 0, 0, 7, 1,   0, 0, 1, 0); // PAUSE
        vt[6]  = mk(0, 1, 1, 0, 7, 1,   0, 0, 1, 0); // START+STOP stays PAUSE
        vt[7]  = mk(0, 1, 0, 0, 7, 1,   0, 0, 1, 0); // resume
        vt[8]  = mk(0, 0, 0, 0, 7, 2,   1, 0, 1, 0); // RUN counting, no clear
        vt[9]  = mk(0, 0, 1, 0, 7, 3,   0, 0, 1, 0); // terminal + STOP -> PAUSE
        vt[10] = mk(0, 1, 0, 0, 7, 3,   0, 0, 1, 0); // resume
        vt[11] = mk(0, 0, 0, 0, 7, 3,   0, 0, 1, 0); // terminal -> DONE
        vt[12] = mk(0, 0, 0, 0, 7, 3,   0, 0, 0, 1); // DONE pulse
        vt[13] = mk(0, 0, 0, 0, 7, 3,   0, 0, 0, 0); // pulse is one cycle
        vt[14] = mk(0, 1, 0, 1, 0, 3,   0, 0, 0, 0); // restart: lim=0, mode 1
        vt[15] = mk(0, 0, 0, 0, 5, 3,   0, 1, 1, 0); // CLEAR
        vt[16] = mk(0, 0, 0, 0, 5, 0,   0, 0, 1, 0); // RUN, terminal at once
        vt[17] = mk(0, 0, 0, 0, 5, 0,   0, 1, 1, 1); // reload CLEAR + DONE
        vt[18] = mk(0, 0, 0, 0, 5, 0,   0, 0, 1, 0); // RUN again
        vt[19] = mk(0, 0, 0, 0, 5, 0,   0, 1, 1, 1); // reload again
        vt[20] = mk(1, 0, 0, 0, 5, 5,   0, 0, 0, 0); // CLR mid-RUN, QIN=5
        vt[21] = mk(0, 0, 0, 0, 5, 5,   0, 0, 0, 0); // stays IDLE
        vt[22] = mk(0, 0, 0, 0, 5, 5,   0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            clr = vt[i].clr; start = vt[i].start; stop = vt[i].stop;
            mode = vt[i].mode; lim = vt[i].lim; qin_tab = vt[i].qin;
            @(negedge clk);
            chk($sformatf("v%0d.ce", i),   ce0,   vt[i].ce);
            chk($sformatf("v%0d.cclr", i), cclr0, vt[i].cclr);
            chk($sformatf("v%0d.busy", i), busy0, vt[i].busy);
            chk($sformatf("v%0d.done", i), done0, vt[i].done);
            $display("vec %2d: start=%b stop=%b qin=%0d -> ce=%b cclr=%b busy=%b done=%b",
                     i, start, stop, qin_tab, ce0, cclr0, busy0, done0);
            @(posedge clk); #1;
        end

        // ---------------- one-shot with counter model ----------------
        use_cnt = 1'b1;
        do_reset();
        lim = 10'd10; mode = 1'b0;
        start_pulse();
        cyc();
        cyc();
        chk("oneshot.first_inc", qin0, 10'd1);
        repeat (20) cyc();
        chk("oneshot.ce_count",   n_ce0,   10);
        chk("oneshot.cclr_count", n_cclr0, 1);
        chk("oneshot.done_count", n_done0, 1);
        chk("oneshot.q_final",    qin0,    10'd10);
        chk("oneshot.busy_end",   busy0,   1'b0);
        $display("one-shot: ce=%0d cclr=%0d done=%0d q=%0d", n_ce0, n_cclr0, n_done0, qin0);

        // ---------------- auto-reload ----------------
        do_reset();
        lim = 10'd3; mode = 1'b1;
        start_pulse();
        repeat (16) cyc();
        chk("reload.cclr_count", n_cclr0, 4);
        chk("reload.done_count", n_done0, 3);
        chk("reload.ce_count",   n_ce0,   9);
        chk("reload.q_max",      q0_max,  3);
        chk("reload.busy",       busy0,   1'b1);
        $display("auto-reload: ce=%0d cclr=%0d done=%0d qmax=%0d", n_ce0, n_cclr0, n_done0, q0_max);

        // ---------------- pause / resume ----------------
        do_reset();
        lim = 10'd20; mode = 1'b0;
        start_pulse();
        for (int k = 0; k < 40 && qin0 != 10'd7; k++) cyc();
        chk("pause.reach7", qin0, 10'd7);
        begin
            int ce_before;
            ce_before = n_ce0;
            stop = 1'b1;
            repeat (5) cyc();
            stop = 1'b0;
            chk("pause.no_ce", n_ce0 - ce_before, 0);
            chk("pause.q_hold", qin0, 10'd7);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (30) cyc();
        chk("pause.q_final",    qin0,    10'd20);
        chk("pause.cclr_count", n_cclr0, 1);
        chk("pause.done_count", n_done0, 1);
        chk("pause.ce_count",   n_ce0,   20);
        $display("pause/resume: ce=%0d cclr=%0d done=%0d q=%0d", n_ce0, n_cclr0, n_done0, qin0);

        // ---------------- prescaler PRESC=3, LIM=4 ----------------
        do_reset();
        lim = 10'd4; mode = 1'b0;
        start_pulse();
        repeat (25) cyc();
        // cycle 1 = IDLE with START, 2 = CLEAR, RUN starts at cycle 3
        chk("presc.first_ce", first_ce3, 6);
        chk("presc.gap_err",  gap_err3,  0);
        chk("presc.ce_count", n_ce3,     4);
        chk("presc.done_cyc", done3_cyc, 20);
        chk("presc.q_final",  qin3,      10'd4);
        $display("prescaler: first_ce=%0d ce=%0d done_cyc=%0d", first_ce3, n_ce3, done3_cyc);

        // ---------------- LIM = 0 ----------------
        do_reset();
        lim = 10'd0; mode = 1'b0;
        start_pulse();
        repeat (6) cyc();
        chk("lim0.ce_count",   n_ce0,   0);
        chk("lim0.done_count", n_done0, 1);
        chk("lim0.cclr_count", n_cclr0, 1);
        chk("lim0.busy_end",   busy0,   1'b0);
        $display("lim0: ce=%0d done=%0d", n_ce0, n_done0);

        // ---------------- LIM = 1023 ----------------
        do_reset();
        lim = 10'd1023; mode = 1'b0;
        start_pulse();
        repeat (1030) cyc();
        chk("full.q_final",    qin0,    10'd1023);
        chk("full.ce_count",   n_ce0,   1023);
        chk("full.done_count", n_done0, 1);
        chk("full.busy_end",   busy0,   1'b0);
        $display("full range: ce=%0d done=%0d q=%0d", n_ce0, n_done0, qin0);

`ifdef CTRL_STICKY_IRQ_EN
        // ---------------- sticky IRQ ----------------
        do_reset();
        lim = 10'd2; mode = 1'b0;
        start_pulse();
        repeat (8) cyc();
        chk("irq.set", irq0, 1'b1);
        repeat (3) cyc();
        chk("irq.sticky", irq0, 1'b1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("irq.ack_clear", irq0, 1'b0);
        lim = 10'd0; mode = 1'b1; ack = 1'b1;
        start_pulse();
        last_done0 = 1'b0;
        for (int k = 0; k < 10 && !last_done0; k++) cyc();
        chk("irq.seen_done", last_done0, 1'b1);
        chk("irq.set_wins", irq0, 1'b1);
        ack = 1'b0;
        clr = 1'b1;
        #1;
        chk("irq.reset", irq0, 1'b0);
        cyc();
        clr = 1'b0;
        $display("irq: sequence complete");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
